// File: rtl/uart_pkg.sv
// Shared constants for the UART receive FIFO: status bit positions,
// default geometry and the stored entry layout {ferr, perr, data}.
package uart_pkg;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_HWM        = 12;
  localparam int ENTRY_W        = 10;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_HWM       = 2;
  localparam int ST_PERR      = 4;
  localparam int ST_FERR      = 5;
  localparam int ST_OV_ERR    = 6;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } cap_state_t;
endpackage

// File: rtl/rx_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port so the
// head entry falls through to the output without a read-latency cycle.
module rx_fifo_ram
  import uart_pkg::*;
#(
  parameter int AW = DEF_DEPTH_LOG2,
  parameter int DW = ENTRY_W
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART RxEngine and the processor data port.
// Optional high-water flag is built only when RX_FIFO_HWM_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int HWM        = DEF_HWM
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       rx_perr,
  input  logic       rx_ferr,
  output logic       rx_ack,
  input  logic       rd_strb,
  input  logic       clr_strb,
  output logic [7:0] dout,
  output logic [7:0] status,
  output logic       full,
  output logic       empty,
  output logic       ov_err,
  output logic       hwm
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  // A high-water level beyond the FIFO depth could never be reached.
  if (HWM < 1 || HWM > DEPTH) begin : g_hwm_range
    $error("uart_rx_fifo: HWM must lie in 1..2**DEPTH_LOG2");
  end

  cap_state_t              state_reg;
  logic                    rx_ack_reg;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
  logic [DEPTH_LOG2:0]     count_reg;
  logic                    ov_err_reg;
  logic [ENTRY_W-1:0]      head;
  logic                    push_req;
  logic                    pop;
  logic                    wr_en;
  logic                    overflow;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == COUNT_FULL);
  assign push_req = (state_reg == IDLE) && rx_rdy;
  assign pop      = rd_strb && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_en    = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg  <= IDLE;
      rx_ack_reg <= 1'b0;
    end else begin
      rx_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_rdy) begin
            rx_ack_reg <= 1'b1;
            state_reg  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!rx_rdy) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ov_err_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (overflow)      ov_err_reg <= 1'b1;
      else if (clr_strb) ov_err_reg <= 1'b0;
    end
  end

  rx_fifo_ram #(
    .AW (DEPTH_LOG2),
    .DW (ENTRY_W)
  ) u_ram (
    .Clk   (Clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata ({rx_ferr, rx_perr, rx_data}),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

`ifdef RX_FIFO_HWM_EN
  assign hwm = (count_reg >= (DEPTH_LOG2+1)'(HWM));
`else
  assign hwm = 1'b0;
`endif

  assign rx_ack = rx_ack_reg;
  assign ov_err = ov_err_reg;
  assign dout   = empty ? 8'h00 : head[7:0];

  always_comb begin
    status               = 8'h00;
    status[ST_NOT_EMPTY] = !empty;
    status[ST_FULL]      = full;
    status[ST_HWM]       = hwm;
    status[ST_PERR]      = !empty && head[8];
    status[ST_FERR]      = !empty && head[9];
    status[ST_OV_ERR]    = ov_err_reg;
  end
endmodule
